// File: rtl/params_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | params_pkg: shared defaults and FSM encoding for the BCM OE scheduler.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package params_pkg;

    localparam int BRIGHTNESS_LEVELS       = 6;
    localparam int BRIGHTNESS_BASE_TIMEOUT = 8;
    localparam int BLANK_CYCLES            = 2;
    localparam int DIM_WIDTH               = 8;
    localparam int STATE_TIMEOUT_OVERLAP   = 67;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } bcm_oe_state_t;

endpackage
`default_nettype wire

// File: rtl/bcm_output_enable_scheduler_on_time_calc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bcm_on_time_calc: plane priority encode, one-hot check, on-time shift,  |
// | optional dim scale (BCM_OE_DIM_EN) and clamp to >= 1. Revision: 1.0     |
// +------------------------------------------------------------------------+
module bcm_on_time_calc #(
    parameter int BRIGHTNESS_LEVELS       = params_pkg::BRIGHTNESS_LEVELS,
    parameter int BRIGHTNESS_BASE_TIMEOUT = params_pkg::BRIGHTNESS_BASE_TIMEOUT,
    parameter int DIM_WIDTH               = params_pkg::DIM_WIDTH,
    parameter int TIMEOUT_WIDTH           = $clog2(BRIGHTNESS_BASE_TIMEOUT) + BRIGHTNESS_LEVELS,
    parameter int IDX_WIDTH               = $clog2(BRIGHTNESS_LEVELS)
) (
    input  logic [BRIGHTNESS_LEVELS-1:0] mask_i,
    input  logic [DIM_WIDTH-1:0]         dim_i,
    output logic [TIMEOUT_WIDTH-1:0]     on_time_o,
    output logic [IDX_WIDTH-1:0]         plane_index_o
);
    import params_pkg::*;

    localparam logic [BRIGHTNESS_LEVELS-1:0] MASK_ONE = 1;
    localparam logic [TIMEOUT_WIDTH-1:0]     T_ONE    = 1;
    localparam logic [TIMEOUT_WIDTH-1:0]     T_BASE   = TIMEOUT_WIDTH'(BRIGHTNESS_BASE_TIMEOUT);

    logic                     one_hot;
    logic [TIMEOUT_WIDTH-1:0] t0;
    logic [TIMEOUT_WIDTH-1:0] t_scaled;

    // Lowest set bit wins, so iterate from the top down.
    always_comb begin
        plane_index_o = '0;
        for (int i = BRIGHTNESS_LEVELS - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                plane_index_o = IDX_WIDTH'(i);
            end
        end
    end

    assign one_hot = (mask_i != '0) && ((mask_i & (mask_i - MASK_ONE)) == '0);
    assign t0      = one_hot ? (T_BASE << plane_index_o) : T_ONE;

`ifdef BCM_OE_DIM_EN
    localparam int PROD_WIDTH = TIMEOUT_WIDTH + DIM_WIDTH;

    logic [PROD_WIDTH-1:0] product;
    logic [PROD_WIDTH-1:0] shifted;

    // (dim+1) <= 2^DIM_WIDTH, so the product always fits PROD_WIDTH bits.
    assign product  = PROD_WIDTH'(t0) * (PROD_WIDTH'(dim_i) + PROD_WIDTH'(1));
    assign shifted  = product >> DIM_WIDTH;
    assign t_scaled = shifted[TIMEOUT_WIDTH-1:0];
`else
    logic unused_dim;

    assign unused_dim = ^dim_i;
    assign t_scaled   = t0;
`endif

    assign on_time_o = (t_scaled == '0) ? T_ONE : t_scaled;

endmodule
`default_nettype wire

// File: rtl/bcm_output_enable_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bcm_output_enable_scheduler: per-latch BCM output-enable pulse with     |
// | blanking guard, abort/restart and done handshake; dim via BCM_OE_DIM_EN.|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module bcm_output_enable_scheduler #(
    parameter int BRIGHTNESS_LEVELS       = params_pkg::BRIGHTNESS_LEVELS,
    parameter int BRIGHTNESS_BASE_TIMEOUT = params_pkg::BRIGHTNESS_BASE_TIMEOUT,
    parameter int BLANK_CYCLES            = params_pkg::BLANK_CYCLES,
    parameter int STATE_TIMEOUT_OVERLAP   = params_pkg::STATE_TIMEOUT_OVERLAP,
    parameter int DIM_WIDTH               = params_pkg::DIM_WIDTH
) (
    input  logic                                 clk_in,
    input  logic                                 reset_n,
    input  logic [BRIGHTNESS_LEVELS-1:0]         brightness_mask_active,
    input  logic [DIM_WIDTH-1:0]                 dim,
    input  logic                                 row_latch,
    output logic                                 output_enable,
    output logic                                 busy,
    output logic                                 done,
    output logic [$clog2(BRIGHTNESS_LEVELS)-1:0] plane_index,
    output logic                                 exceeded_overlap_time
);
    import params_pkg::*;

    localparam int          TIMEOUT_WIDTH = $clog2(BRIGHTNESS_BASE_TIMEOUT) + BRIGHTNESS_LEVELS;
    localparam int          IDX_WIDTH     = $clog2(BRIGHTNESS_LEVELS);
    localparam int          BLANK_WIDTH   = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [31:0] OVERLAP_LIMIT = 32'(STATE_TIMEOUT_OVERLAP);

    bcm_oe_state_t            state_q, state_d;
    logic                     row_latch_q;
    logic                     start_event;
    logic [BLANK_WIDTH-1:0]   blank_cnt_q, blank_cnt_d;
    logic [TIMEOUT_WIDTH-1:0] elapsed_q, elapsed_d;
    logic [TIMEOUT_WIDTH-1:0] on_time_q, on_time_d;
    logic [TIMEOUT_WIDTH-1:0] calc_on_time;
    logic [IDX_WIDTH-1:0]     plane_index_q, plane_index_d;
    logic [IDX_WIDTH-1:0]     calc_plane_index;
    logic                     output_enable_q;
    logic                     busy_q;
    logic                     done_q, done_d;

    bcm_on_time_calc #(
        .BRIGHTNESS_LEVELS       (BRIGHTNESS_LEVELS),
        .BRIGHTNESS_BASE_TIMEOUT (BRIGHTNESS_BASE_TIMEOUT),
        .DIM_WIDTH               (DIM_WIDTH),
        .TIMEOUT_WIDTH           (TIMEOUT_WIDTH),
        .IDX_WIDTH               (IDX_WIDTH)
    ) u_on_time_calc (
        .mask_i        (brightness_mask_active),
        .dim_i         (dim),
        .on_time_o     (calc_on_time),
        .plane_index_o (calc_plane_index)
    );

    // Falling edge of the latch strobe starts (or restarts) a pulse.
    assign start_event = row_latch_q && !row_latch;

    always_comb begin
        state_d       = state_q;
        blank_cnt_d   = '0;
        elapsed_d     = '0;
        on_time_d     = on_time_q;
        plane_index_d = plane_index_q;
        done_d        = 1'b0;

        if (start_event) begin
            on_time_d     = calc_on_time;
            plane_index_d = calc_plane_index;
            if (BLANK_CYCLES == 0) begin
                state_d   = ON;
                elapsed_d = TIMEOUT_WIDTH'(1);
            end else begin
                state_d     = BLANK;
                blank_cnt_d = BLANK_WIDTH'(1);
            end
        end else begin
            case (state_q)
                BLANK: begin
                    if (blank_cnt_q >= BLANK_WIDTH'(BLANK_CYCLES)) begin
                        state_d   = ON;
                        elapsed_d = TIMEOUT_WIDTH'(1);
                    end else begin
                        blank_cnt_d = blank_cnt_q + BLANK_WIDTH'(1);
                    end
                end
                ON: begin
                    if (elapsed_q >= on_time_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        elapsed_d = elapsed_q + TIMEOUT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            row_latch_q     <= 1'b0;
            blank_cnt_q     <= '0;
            elapsed_q       <= '0;
            on_time_q       <= '0;
            plane_index_q   <= '0;
            output_enable_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_latch_q     <= row_latch;
            blank_cnt_q     <= blank_cnt_d;
            elapsed_q       <= elapsed_d;
            on_time_q       <= on_time_d;
            plane_index_q   <= plane_index_d;
            output_enable_q <= (state_d == ON);
            busy_q          <= (state_d != IDLE);
            done_q          <= done_d;
        end
    end

    assign output_enable         = output_enable_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign plane_index           = plane_index_q;
    assign exceeded_overlap_time = (state_q == ON) && (32'(elapsed_q) > OVERLAP_LIMIT);

endmodule
`default_nettype wire
